// File: rtl/irr_priority_resolver.sv
// IRR capture, masking and fixed/rotating priority resolution with INTA freeze for the 8259 front end.
// Optional polling support is built when POLL_MODE_EN is defined.
module irr_priority_resolver #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [2:0] RESET_LOWEST = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    input  logic       special_mask,
    input  logic       rotate_en,
    input  logic       eoi_done,
    input  logic [2:0] last_serviced_idx,
    input  logic       rotate_load,
    input  logic [2:0] rotate_set_lowest,
    input  logic       inta_first,
    input  logic       inta_second,
`ifdef POLL_MODE_EN
    input  logic       poll_read,
    output logic [7:0] poll_word,
`endif
    output logic       int_req,
    output logic [2:0] highest_priority_idx,
    output logic [7:0] irr,
    output logic [2:0] lowest_prio,
    output logic       spurious
);

    typedef enum logic {ST_IDLE = 1'b0, ST_FROZEN = 1'b1} frz_state_e;

    // Bit r of the result is the bit of vec that holds rank r when rank 0 sits at index base.
    function automatic logic [7:0] rotate_down(input logic [7:0] vec, input logic [2:0] base);
        logic [7:0] res;
        res = 8'd0;
        for (int i = 0; i < 8; i++) begin
            res[i] = vec[base + 3'(i)];
        end
        return res;
    endfunction

    // Returns {found, position of lowest set bit}.
    function automatic logic [3:0] first_set(input logic [7:0] vec);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    logic [7:0] sync_r [SYNC_STAGES];
    logic [7:0] irs_prev_r;
    logic [7:0] irr_r;
    logic [2:0] lowest_r;
    frz_state_e state_r;
    logic       int_req_r;
    logic [2:0] hpi_r;
    logic       spurious_r;

    logic [7:0] irs_s;
    logic [2:0] base_s;
    logic [7:0] req_s;
    logic [3:0] cand_s;
    logic [3:0] isr_top_s;
    logic [3:0] open_s;
    logic       valid_s;
    logic [2:0] rank_s;
    logic [2:0] win_s;
    logic       ack_s;
    logic [7:0] clr_s;
    logic [7:0] irr_nxt_s;

    assign irs_s = sync_r[SYNC_STAGES-1];

    // Input synchronizer chain and previous-sample register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 8'd0;
            end
            irs_prev_r <= 8'd0;
        end else begin
            sync_r[0] <= ir;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            irs_prev_r <= irs_s;
        end
    end

    // Circular priority resolution; ranks count down from (lowest+1).
    always_comb begin
        base_s    = lowest_r + 3'd1;
        req_s     = irr_r & ~imr;
        cand_s    = first_set(rotate_down(req_s, base_s));
        isr_top_s = first_set(rotate_down(isr, base_s));
        open_s    = first_set(rotate_down(req_s & ~isr, base_s));
        if (special_mask) begin
            valid_s = open_s[3];
            rank_s  = open_s[2:0];
        end else begin
            // An in-service bit blocks its own rank and everything below it.
            valid_s = cand_s[3] && (!isr_top_s[3] || (cand_s[2:0] < isr_top_s[2:0]));
            rank_s  = cand_s[2:0];
        end
        win_s = rank_s + base_s;
    end

    // Next IRR value: capture by edge or level, then acknowledge clear which overrides any set.
    always_comb begin
        ack_s = inta_first && (state_r == ST_IDLE) && valid_s;
`ifdef POLL_MODE_EN
        clr_s = (ack_s || (poll_read && valid_s)) ? (8'd1 << win_s) : 8'd0;
`else
        clr_s = ack_s ? (8'd1 << win_s) : 8'd0;
`endif
        if (ltim) begin
            irr_nxt_s = irs_s;
        end else begin
            irr_nxt_s = irs_s & (irr_r | ~irs_prev_r);
        end
        irr_nxt_s = irr_nxt_s & ~clr_s;
    end

    // IRR register and rotating lowest-priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_r    <= 8'd0;
            lowest_r <= RESET_LOWEST;
        end else begin
            irr_r <= irr_nxt_s;
            if (rotate_load) begin
                lowest_r <= rotate_set_lowest;
            end else if (rotate_en && eoi_done) begin
                lowest_r <= last_serviced_idx;
            end else begin
                lowest_r <= lowest_r;
            end
        end
    end

    // Freeze FSM holding the winner stable between the two INTA pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            int_req_r  <= 1'b0;
            hpi_r      <= 3'd0;
            spurious_r <= 1'b0;
        end else begin
            spurious_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (inta_first) begin
                        state_r   <= ST_FROZEN;
                        int_req_r <= 1'b0;
                        if (valid_s) begin
                            hpi_r <= win_s;
                        end else begin
                            hpi_r      <= 3'd7;
                            spurious_r <= 1'b1;
                        end
                    end else begin
                        int_req_r <= valid_s;
                        if (valid_s) begin
                            hpi_r <= win_s;
                        end else begin
                            hpi_r <= hpi_r;
                        end
                    end
                end
                ST_FROZEN: begin
                    int_req_r <= 1'b0;
                    if (inta_second) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_FROZEN;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    int_req_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef POLL_MODE_EN
    logic [7:0] poll_word_r;

    // Poll result captured on each poll_read and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_word_r <= 8'd0;
        end else if (poll_read) begin
            poll_word_r <= {valid_s, 4'b0000, (valid_s ? win_s : 3'd7)};
        end else begin
            poll_word_r <= poll_word_r;
        end
    end

    assign poll_word = poll_word_r;
`endif

    assign int_req              = int_req_r;
    assign highest_priority_idx = hpi_r;
    assign irr                  = irr_r;
    assign lowest_prio          = lowest_r;
    assign spurious             = spurious_r;

endmodule

// File: doc/irr_priority_resolver.md
Name: irr_priority_resolver

Overview:
- Upstream stage of the 8259 in-service logic.
- Captures IR0..IR7 requests into the Interrupt Request Register (IRR) and applies the mask (IMR).
- Resolves the highest-priority pending request under fixed or rotating priority and raises INT.
- Freezes the winning index across the INTA sequence so the in-service stage sees a stable highest_priority_idx.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each ir input (minimum 2).
- RESET_LOWEST, 7, reset value of the lowest-priority index (7 gives IR0 highest).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ir  input  8  raw interrupt request lines
- ltim  input  1  1 = level-triggered, 0 = edge-triggered (from ICW1)
- imr  input  8  interrupt mask, 1 = masked (OCW1)
- isr  input  8  interrupts_in_service from the in-service stage
- special_mask  input  1  special mask mode (OCW3 SMM)
- rotate_en  input  1  automatic rotation on EOI
- eoi_done  input  1  one-cycle pulse when an EOI completes
- last_serviced_idx  input  3  index just retired by the in-service stage
- rotate_load  input  1  one-cycle pulse: set priority explicitly
- rotate_set_lowest  input  3  new lowest-priority index
- inta_first  input  1  one-cycle pulse, synchronized first INTA
- inta_second  input  1  one-cycle pulse, synchronized second INTA
- int_req  output  1  INT to CPU
- highest_priority_idx  output  3  winning index to the in-service stage
- irr  output  8  current IRR contents
- lowest_prio  output  3  current lowest-priority index
- spurious  output  1  one-cycle pulse on spurious acknowledge

Behaviour:
- Reset (async, rst_n low):
  - irr = 0, synchronizers = 0, int_req = 0, highest_priority_idx = 0, spurious = 0.
  - lowest_prio = RESET_LOWEST; freeze state = IDLE.
- Input capture: ir passes through SYNC_STAGES flops to give irs; all further logic uses irs.
- Edge mode (ltim = 0):
  - A rising edge on irs[n] (previous 0, current 1) sets irr[n] on the next clk.
  - irr[n] clears whenever irs[n] = 0.
- Level mode (ltim = 1): irr[n] follows irs[n] each cycle.
- Clear on acknowledge: inta_first clears irr[w], where w is the frozen winner.
  - Edge mode: the line must fall and rise again to re-request.
  - Level mode: the bit re-sets on the next cycle if irs[w] is still high.
  - If a set and an ack-clear hit the same bit in the same cycle, the clear wins.
- Priority order: circular, highest = (lowest_prio+1) mod 8 through lowest_prio.
  - req = irr & ~imr.
  - Candidate = first set bit of req in that circular order.
- In-service blocking (special_mask = 0):
  - Candidate qualifies only if its rank is strictly higher than the highest-ranked set isr bit (same circular order).
  - Any isr bit blocks equal and lower ranks.
- In-service blocking (special_mask = 1): requests whose isr bit is clear qualify, regardless of other isr bits.
- Output timing: int_req and highest_priority_idx are registered, with one clk latency from irr/imr/isr/lowest_prio changes.
- Freeze FSM:
  - IDLE: outputs track the resolver. On inta_first, latch the winner into highest_priority_idx and go to FROZEN.
  - If no qualified request exists at inta_first: latch 7, pulse spurious for one cycle, irr unchanged.
  - FROZEN: highest_priority_idx and int_req are held (int_req forced 0). On inta_second, return to IDLE.
  - FROZEN: a second inta_first is ignored.
- Rotation:
  - rotate_load sets lowest_prio = rotate_set_lowest.
  - Otherwise, rotate_en && eoi_done sets lowest_prio = last_serviced_idx.
  - If both occur in the same cycle, rotate_load wins. Rotation takes effect the next cycle.
- Masking a pending request clears int_req on the next cycle and does not clear irr.

Optional Feature:
- Macro: POLL_MODE_EN.
- With it defined, add ports poll_read (input, 1-bit pulse) and poll_word (output, 8 bits).
  - On poll_read, poll_word = {int_pending, 4'b0000, idx}, registered and held until the next poll_read.
  - poll_read clears the winning irr bit exactly as inta_first does.
  - poll_read does not enter FROZEN and does not raise spurious.
  - poll_word resets to 0.
- Without it, these ports do not exist and no poll logic is built.

Test Plan:
- Edge mode, imr = 0, isr = 0, pulse ir[3] high: irr = 8'h08 after SYNC_STAGES+1 clk, then int_req = 1 and highest_priority_idx = 3 one clk later. inta_first clears irr to 0; inta_second returns to IDLE.
- ir[5] and ir[2] raised together, lowest_prio = 7: idx = 2. rotate_load with rotate_set_lowest = 2: idx = 5 next cycle.
- isr = 8'h02, irr = 8'h08, special_mask = 0: int_req = 0. Set special_mask = 1: int_req = 1 with idx = 3.
- Level mode, ir[6] held high, imr = 8'h40: int_req = 0. Clear imr: int_req = 1, idx = 6. After inta_first, irr[6] re-sets the next cycle.
- Raise ir[4], then drop it before inta_first: inta_first yields spurious pulse and idx = 7. rotate_en = 1 with eoi_done and last_serviced_idx = 4: lowest_prio = 4.
- Assert rst_n low while FROZEN with irr = 8'hFF: all outputs go to reset values immediately; lowest_prio = 7.
